keyboard_event_queue: RTL
=========================

// Module: keyboard_event_queue
// PURPOSE
//  Sequences raw PS/2 scan bytes into key events and buffers them for the CPU.
//  Strips E0 (extended) and F0 (break) prefixes, discards keyboard control bytes,
//  and queues {ext,brk,code} events in a FIFO. Presents the head event as
//  key_status/keycode to the READKEY writeback unit; pop retires it.
//  Sits between the PS/2 byte receiver and the READKEY path.
// PARAMETERS
//  DEPTH_LOG2   3      FIFO depth = 2**DEPTH_LOG2 events (8)
//  TIMEOUT      50000  cycles a prefix state may wait for its next byte before abort
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  rst_n          in   1   asynchronous active-low reset
//  scan_valid     in   1   one-cycle strobe: scan_data holds a new byte
//  scan_data      in   8   byte from PS/2 receiver
//  pop            in   1   one-cycle strobe: head event consumed (READKEY retired)
//  clear_overflow in   1   clears sticky overflow flag
//  key_status     out  8   [0] brk, [1] event valid, [2] ext, [3] overflow, [7:4]=0
//  keycode        out  8   code byte of head event (0 when empty)
//  count          out  DEPTH_LOG2+1  events currently queued
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, rd/wr ptrs 0, count=0, key_status=0, keycode=0,
//   overflow=0, timeout counter=0. Reset may assert mid-sequence; partial prefix lost.
//  Decode FSM (advances only on scan_valid):
//   IDLE:   E0->EXT; F0->BRK; AA,FA,FE,00,FF->discard, stay; else push{0,0,b}.
//   EXT:    F0->EXT_BRK; E0->stay EXT; else push{1,0,b}, ->IDLE.
//   BRK:    push{0,1,b}, ->IDLE (any byte, incl. E0/F0 treated as code).
//   EXT_BRK: push{1,1,b}, ->IDLE.
//  Timeout: in EXT/BRK/EXT_BRK, counter increments each cycle without scan_valid;
//   reaching TIMEOUT-1 -> IDLE, counter=0, no push. Counter=0 in IDLE or on scan_valid.
//  FIFO: 10-bit entries {ext,brk,code}, circular, ptrs wrap mod 2**DEPTH_LOG2.
//   Push when count==DEPTH: entry dropped, overflow<=1 (sticky), ptrs unchanged.
//   Pop when count==0: ignored. Push+pop same cycle, count>0: both occur, count same.
//   Push+pop same cycle, count==DEPTH: pop first, push accepted, no overflow.
//   Push+pop, count==0: push accepted, pop ignored.
//   clear_overflow and overflow-set in same cycle: set wins.
//  Outputs registered, show-ahead: head entry drives key_status/keycode.
//   Byte completing an event at edge N -> key_status[1]=1 after edge N+1 (1-cycle).
//   pop at edge N -> next entry (or zeros if empty) visible after edge N+1.
//   When empty: key_status[2:0]=0, keycode=0; key_status[3] = overflow always.
//  Consumer must assert pop only while key_status[1]=1 and at most once per event;
//   pop for an event must not be issued until its key_status[1] is seen.
// TESTING
//  1C -> key_status=8'h02, keycode=8'h1C one cycle later; pop -> key_status=0, count=0.
//  F0 1C -> status 8'h03 code 1C; E0 75 -> 8'h06 code 75; E0 F0 75 -> 8'h07 code 75.
//  AA, FA, FE bytes in IDLE -> count stays 0, no event; E0 E0 6B -> one event {1,0,6B}.
//  9 events with no pop -> count=8, 9th dropped, status[3]=1; clear_overflow -> 0;
//   pop x8 returns events 1..8 in order, ptr wrap correct.
//  Full FIFO, push+pop same cycle -> count stays 8, overflow stays 0, order kept.
//  E0 then no byte for TIMEOUT cycles -> IDLE; next 1C -> {0,0,1C}; rst_n low after F0 -> all zero.

Source files
------------

// File: rtl/keyboard_event_queue.sv
// Turns PS/2 scan bytes into {ext,brk,code} key events and queues them for READKEY.
// The head event is shown on registered outputs (show-ahead); a pop retires it.
module keyboard_event_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_scan_valid,
  input  logic [7:0]            i_scan_data,
  input  logic                  i_pop,
  input  logic                  i_clear_overflow,
  output logic [7:0]            o_key_status,
  output logic [7:0]            o_keycode,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [TW-1:0]         r_tmo;
  logic                  w_tmo_hit;
  logic                  w_push;
  logic [9:0]            w_push_data;
  logic                  w_ctrl_byte;

  logic [9:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr;
  logic [DEPTH_LOG2-1:0] r_rd;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;
  logic                  w_full;
  logic                  w_pop_ok;
  logic                  w_push_ok;
  logic                  w_ovf_set;
  logic                  w_nonempty;
  logic [9:0]            w_head;
  logic [7:0]            r_key_status;
  logic [7:0]            r_keycode;

  // Keyboard control/ack bytes that never form an event when seen in IDLE
  assign w_ctrl_byte = (i_scan_data == 8'hAA) || (i_scan_data == 8'hFA) ||
                       (i_scan_data == 8'hFE) || (i_scan_data == 8'h00) ||
                       (i_scan_data == 8'hFF);
  assign w_tmo_hit   = (r_state != S_IDLE) && !i_scan_valid &&
                       (r_tmo == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = '0;
    if (i_scan_valid) begin
      case (r_state)
        S_IDLE: begin
          if (i_scan_data == 8'hE0)      w_state_nxt = S_EXT;
          else if (i_scan_data == 8'hF0) w_state_nxt = S_BRK;
          else if (!w_ctrl_byte) begin
            w_push      = 1'b1;
            w_push_data = {2'b00, i_scan_data};
          end
        end
        S_EXT: begin
          if (i_scan_data == 8'hF0)      w_state_nxt = S_EXT_BRK;
          else if (i_scan_data != 8'hE0) begin
            w_push      = 1'b1;
            w_push_data = {2'b10, i_scan_data};
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          w_push      = 1'b1;
          w_push_data = {2'b01, i_scan_data};
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_push      = 1'b1;
          w_push_data = {2'b11, i_scan_data};
          w_state_nxt = S_IDLE;
        end
      endcase
    end else if (w_tmo_hit) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_scan_valid || (r_state == S_IDLE) || w_tmo_hit) r_tmo <= '0;
      else                                                   r_tmo <= r_tmo + 1'b1;
    end
  end

  // A pop on a full FIFO frees a slot for a same-cycle push
  assign w_full     = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_pop_ok   = i_pop && w_nonempty;
  assign w_push_ok  = w_push && (!w_full || w_pop_ok);
  assign w_ovf_set  = w_push && w_full && !w_pop_ok;
  assign w_head     = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr] <= w_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_key_status <= 8'h00;
      r_keycode    <= 8'h00;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)             r_ovf <= 1'b1;
      else if (i_clear_overflow) r_ovf <= 1'b0;
      r_key_status <= {4'b0000, r_ovf, w_nonempty & w_head[9], w_nonempty,
                       w_nonempty & w_head[8]};
      r_keycode    <= w_nonempty ? w_head[7:0] : 8'h00;
    end
  end

  assign o_key_status = r_key_status;
  assign o_keycode    = r_keycode;
  assign o_count      = r_count;

endmodule
